// File: rtl/fetch_prefetch_buffer_if.sv
// Instruction memory read bus: registered address/read request, one-cycle
// ready pulse that returns the read data.
interface fetch_prefetch_buffer_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_read;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic                  mem_ready;

   modport master (
      output mem_addr,
      output mem_read,
      input  mem_rdata,
      input  mem_ready
   );

   modport slave (
      input  mem_addr,
      input  mem_read,
      output mem_rdata,
      output mem_ready
   );
endinterface

// File: rtl/fetch_prefetch_buffer.sv
// Sequential instruction prefetcher: one outstanding word read at a time, returned
// words buffered with their PCs in a show-ahead FIFO; redirects flush and drain.
module fetch_prefetch_buffer #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    DEPTH      = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = {ADDR_WIDTH{1'b0}}
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  instr_valid,
   output logic [DATA_WIDTH-1:0] instr_data,
   output logic [ADDR_WIDTH-1:0] instr_pc,
   input  logic                  instr_ready,
   fetch_prefetch_buffer_if.master mem
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_BUSY  = 2'b01,
      ST_DRAIN = 2'b10
   } state_t;

   state_t                state_r, state_nxt_s;
   logic [ADDR_WIDTH-1:0] fetch_pc_r, fetch_pc_nxt_s;
   logic [ADDR_WIDTH-1:0] mem_addr_r, mem_addr_nxt_s;
   logic                  mem_read_r, mem_read_nxt_s;
   logic [CNT_W-1:0]      count_r;
   logic [PTR_W-1:0]      rd_ptr_r, wr_ptr_r;
   logic [ADDR_WIDTH-1:0] pc_mem_r   [DEPTH];
   logic [DATA_WIDTH-1:0] data_mem_r [DEPTH];
   logic                  push_s;
   logic                  pop_s;
   logic [ADDR_WIDTH-1:0] redirect_al_s;

   assign redirect_al_s = redirect_pc & {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
   // A redirect flushes the FIFO, so a pop in the same cycle is dropped.
   assign pop_s         = (count_r != {CNT_W{1'b0}}) && instr_ready && !redirect_valid;

   assign instr_valid   = (count_r != {CNT_W{1'b0}});
   assign instr_data    = data_mem_r[rd_ptr_r];
   assign instr_pc      = pc_mem_r[rd_ptr_r];
   assign mem.mem_addr  = mem_addr_r;
   assign mem.mem_read  = mem_read_r;

   // Next-state, fetch PC and memory request decode.
   always_comb begin
      state_nxt_s    = state_r;
      fetch_pc_nxt_s = fetch_pc_r;
      mem_addr_nxt_s = mem_addr_r;
      mem_read_nxt_s = mem_read_r;
      push_s         = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (redirect_valid) begin
               fetch_pc_nxt_s = redirect_al_s;
            end else if (count_r < CNT_W'(DEPTH)) begin
               mem_read_nxt_s = 1'b1;
               mem_addr_nxt_s = fetch_pc_r;
               state_nxt_s    = ST_BUSY;
            end else begin
               mem_read_nxt_s = 1'b0;
            end
         end
         ST_BUSY: begin
            if (redirect_valid) begin
               fetch_pc_nxt_s = redirect_al_s;
               if (mem.mem_ready) begin
                  mem_read_nxt_s = 1'b0;
                  state_nxt_s    = ST_IDLE;
               end else begin
                  state_nxt_s    = ST_DRAIN;
               end
            end else if (mem.mem_ready) begin
               push_s         = 1'b1;
               fetch_pc_nxt_s = fetch_pc_r + ADDR_WIDTH'(3'd4);
               mem_read_nxt_s = 1'b0;
               state_nxt_s    = ST_IDLE;
            end else begin
               state_nxt_s    = ST_BUSY;
            end
         end
         ST_DRAIN: begin
            if (redirect_valid) begin
               fetch_pc_nxt_s = redirect_al_s;
            end else begin
               fetch_pc_nxt_s = fetch_pc_r;
            end
            if (mem.mem_ready) begin
               mem_read_nxt_s = 1'b0;
               state_nxt_s    = ST_IDLE;
            end else begin
               state_nxt_s    = ST_DRAIN;
            end
         end
         default: begin
            mem_read_nxt_s = 1'b0;
            state_nxt_s    = ST_IDLE;
         end
      endcase
   end

   // FSM state, fetch PC and registered memory request.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state_r    <= ST_IDLE;
         fetch_pc_r <= RESET_PC;
         mem_addr_r <= RESET_PC;
         mem_read_r <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         fetch_pc_r <= fetch_pc_nxt_s;
         mem_addr_r <= mem_addr_nxt_s;
         mem_read_r <= mem_read_nxt_s;
      end
   end

   // FIFO occupancy and pointers; pointers wrap naturally as DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         count_r  <= {CNT_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         wr_ptr_r <= {PTR_W{1'b0}};
      end else if (redirect_valid) begin
         count_r  <= {CNT_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         wr_ptr_r <= {PTR_W{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1'b1);
            2'b01:   count_r <= count_r - CNT_W'(1'b1);
            default: count_r <= count_r;
         endcase
      end
   end

   // FIFO storage; contents are qualified by count, so no reset is needed.
   always_ff @(posedge clk) begin
      if (push_s) begin
         pc_mem_r[wr_ptr_r]   <= fetch_pc_r;
         data_mem_r[wr_ptr_r] <= mem.mem_rdata;
      end
   end
endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Randomized and directed bench for fetch_prefetch_buffer against a queue-based
// model of the expected sequential instruction stream.
module tb_fetch_prefetch_buffer;
   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          redirect_valid;
   logic [AW-1:0] redirect_pc;
   logic          instr_valid;
   logic [DW-1:0] instr_data;
   logic [AW-1:0] instr_pc;
   logic          instr_ready;

   fetch_prefetch_buffer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_if ();

   fetch_prefetch_buffer #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .RESET_PC(32'h0000_0000)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr_data     (instr_data),
      .instr_pc       (instr_pc),
      .instr_ready    (instr_ready),
      .mem            (mem_if)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // model: expected FIFO contents (PCs) and the next address to fetch
   logic [31:0] q[$];
   logic [31:0] fetch_ptr;
   bit          stale;
   int          mem_wait;
   int          mem_lat;
   bit          prev_read, prev_rdy, rose;
   logic [31:0] prev_addr;
   int          cyc;
   logic [31:0] req_log[$];
   int          req_cyc[$];
   logic [31:0] pop_log[$];
   bit          drv_redir, drv_ready, redir_on_ready;
   logic [31:0] drv_redir_pc;

   function automatic logic [31:0] imem(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC001_D00D;
   endfunction

   function automatic logic [31:0] qat(input logic [31:0] qq[$], input int i);
      if (i < qq.size()) return qq[i];
      return 32'hDEAD_DEAD;
   endfunction

   task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      fetch_ptr = 32'h0;
      stale     = 1'b0;
      mem_wait  = 0;
      prev_read = 1'b0;
      prev_rdy  = 1'b0;
      prev_addr = 32'h0;
      rose      = 1'b0;
      redirect_valid   = 1'b0;
      mem_if.mem_ready = 1'b0;
   endtask

   // One cycle: observe at negedge, drive inputs for the next posedge, advance model.
   task automatic step();
      bit          rdy, redir, pop, do_push;
      logic [31:0] rpc;
      @(negedge clk);
      cyc++;
      rose = 1'b0;
      if (prev_rdy) chk_eq("read_gap", mem_if.mem_read, 1'b0);
      else if (mem_if.mem_read && prev_read) chk_eq("addr_stable", mem_if.mem_addr, prev_addr);
      if (mem_if.mem_read && !prev_read) begin
         rose = 1'b1;
         chk_eq("req_addr", mem_if.mem_addr, fetch_ptr);
         req_log.push_back(mem_if.mem_addr);
         req_cyc.push_back(cyc);
         mem_wait = mem_lat;
      end
      chk_eq("instr_valid", instr_valid, q.size() != 0);
      if (q.size() != 0) begin
         chk_eq("instr_pc", instr_pc, q[0]);
         chk_eq("instr_data", instr_data, imem(q[0]));
      end
      rdy = 1'b0;
      if (mem_if.mem_read && !prev_rdy) begin
         if (mem_wait == 0) rdy = 1'b1;
         else mem_wait--;
      end
      redir = drv_redir;
      rpc   = drv_redir_pc;
      drv_redir = 1'b0;
      instr_ready = drv_ready;
      if (rdy && redir_on_ready) begin
         redir = 1'b1;
         instr_ready = 1'b1;
         redir_on_ready = 1'b0;
      end
      redirect_valid    = redir;
      redirect_pc       = redir ? rpc : $urandom();
      mem_if.mem_ready  = rdy;
      mem_if.mem_rdata  = rdy ? imem(mem_if.mem_addr) : $urandom();
      do_push = rdy && !redir && !stale;
      if (do_push) chk_eq("push_room", q.size() < DEPTH, 1'b1);
      pop = (q.size() != 0) && instr_ready && !redir;
      if (pop) begin
         pop_log.push_back(q[0]);
         void'(q.pop_front());
      end
      if (do_push) begin
         q.push_back(fetch_ptr);
         fetch_ptr = fetch_ptr + 32'd4;
      end
      if (rdy) stale = 1'b0;
      if (redir) begin
         q.delete();
         fetch_ptr = rpc & 32'hFFFF_FFFC;
         if (mem_if.mem_read && !rdy) stale = 1'b1;
      end
      prev_read = mem_if.mem_read;
      prev_addr = mem_if.mem_addr;
      prev_rdy  = rdy;
   endtask

   task automatic redirect_to(input logic [31:0] pc);
      drv_redir    = 1'b1;
      drv_redir_pc = pc;
      step();
      req_log.delete();
      req_cyc.delete();
      pop_log.delete();
   endtask

   task automatic wait_addr(input logic [31:0] a);
      bit found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         step();
         if (rose && mem_if.mem_addr == a) found = 1'b1;
      end
      chk_eq("wait_addr", found, 1'b1);
   endtask

   task automatic wait_rise();
      bit found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         step();
         found = rose;
      end
      chk_eq("wait_rise", found, 1'b1);
   endtask

   initial begin
      rst_n = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = 32'h0;
      instr_ready = 1'b0;
      mem_if.mem_ready = 1'b0;
      mem_if.mem_rdata = 32'h0;
      drv_redir = 1'b0; drv_ready = 1'b0; redir_on_ready = 1'b0;
      drv_redir_pc = 32'h0;
      mem_lat = 5;
      cyc = 0;
      repeat (3) @(negedge clk);
      chk_eq("rst_mem_read", mem_if.mem_read, 1'b0);
      chk_eq("rst_mem_addr", mem_if.mem_addr, 32'h0);
      chk_eq("rst_instr_valid", instr_valid, 1'b0);
      model_reset();
      rst_n = 1'b0;

      // reset release, latency-5 memory, core always ready
      drv_ready = 1'b1;
      repeat (40) step();
      chk_eq("t1_req0", qat(req_log, 0), 32'h0);
      chk_eq("t1_req1", qat(req_log, 1), 32'h4);
      chk_eq("t1_req2", qat(req_log, 2), 32'h8);
      chk_eq("t1_period", (req_cyc.size() > 1) ? req_cyc[1] - req_cyc[0] : 0, mem_lat + 2);
      chk_eq("t1_pop0", qat(pop_log, 0), 32'h0);
      chk_eq("t1_pop2", qat(pop_log, 2), 32'h8);

      // fill the FIFO with the core stalled, then a single pop
      drv_ready = 1'b0;
      mem_lat = 2;
      redirect_to(32'h0);
      repeat (40) step();
      chk_eq("t2_nreq", req_log.size(), 4);
      chk_eq("t2_req3", qat(req_log, 3), 32'hC);
      for (int i = 0; i < 5; i++) begin
         step();
         chk_eq("t2_full_idle", mem_if.mem_read, 1'b0);
      end
      chk_eq("t2_full_valid", instr_valid, 1'b1);
      req_log.delete();
      drv_ready = 1'b1;
      step();
      drv_ready = 1'b0;
      repeat (20) step();
      chk_eq("t2_one_req", req_log.size(), 1);
      chk_eq("t2_req_10", qat(req_log, 0), 32'h10);

      // redirect while the read of 0x8 is outstanding
      drv_ready = 1'b1;
      mem_lat = 5;
      redirect_to(32'h0);
      wait_addr(32'h8);
      redirect_to(32'h100);
      step();
      chk_eq("t3_flushed", instr_valid, 1'b0);
      repeat (60) step();
      chk_eq("t3_req0", qat(req_log, 0), 32'h100);
      chk_eq("t3_pop0", qat(pop_log, 0), 32'h100);

      // two redirects during drain, then redirect coincident with mem_ready and a pop
      mem_lat = 6;
      wait_rise();
      redirect_to(32'h200);
      step();
      redirect_to(32'h300);
      repeat (40) step();
      chk_eq("t4_req0", qat(req_log, 0), 32'h300);
      chk_eq("t4_pop0", qat(pop_log, 0), 32'h300);
      drv_ready = 1'b0;
      repeat (10) step();
      drv_redir_pc = 32'h300;
      redir_on_ready = 1'b1;
      for (int i = 0; i < 50 && redir_on_ready; i++) step();
      chk_eq("t4_coincide", redir_on_ready, 1'b0);
      req_log.delete();
      pop_log.delete();
      step();
      chk_eq("t4_count0", instr_valid, 1'b0);
      drv_ready = 1'b1;
      repeat (30) step();
      chk_eq("t4_req_after", qat(req_log, 0), 32'h300);
      chk_eq("t4_pop_after", qat(pop_log, 0), 32'h300);

      // unaligned redirect and address wrap
      mem_lat = 3;
      redirect_to(32'h103);
      repeat (30) step();
      chk_eq("t5_align_req", qat(req_log, 0), 32'h100);
      chk_eq("t5_align_pop", qat(pop_log, 0), 32'h100);
      redirect_to(32'hFFFF_FFFC);
      repeat (30) step();
      chk_eq("t5_wrap_pop0", qat(pop_log, 0), 32'hFFFF_FFFC);
      chk_eq("t5_wrap_pop1", qat(pop_log, 1), 32'h0);

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         mem_lat   = $urandom_range(1, 6);
         drv_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 39) == 0) begin
            drv_redir    = 1'b1;
            drv_redir_pc = $urandom_range(0, 1) ? (32'hFFFF_FFF0 + $urandom_range(0, 15)) : $urandom();
         end
         step();
      end

      // asynchronous reset in the middle of a read
      mem_lat = 8;
      drv_ready = 1'b1;
      wait_rise();
      step();
      #2 rst_n = 1'b1;
      #1;
      chk_eq("t7_mem_read", mem_if.mem_read, 1'b0);
      chk_eq("t7_instr_valid", instr_valid, 1'b0);
      chk_eq("t7_mem_addr", mem_if.mem_addr, 32'h0);
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      req_log.delete();
      pop_log.delete();
      repeat (30) step();
      chk_eq("t7_req0", qat(req_log, 0), 32'h0);
      chk_eq("t7_pop0", qat(pop_log, 0), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
